// File: rtl/write_wptr_addr_full.sv
// Write-side pointer stage of the async FIFO: binary/Gray write pointer,
// full and almost-full detection against the synchronised read pointer, fill count and sticky overflow.
module write_wptr_addr_full #(
  parameter int ADDR_WIDTH = 5,
  parameter int AF_LEVEL   = 28
) (
  input  logic                  CLK_WRITE,
  input  logic                  W_RST,
  input  logic                  W_EN,
  input  logic [ADDR_WIDTH:0]   rptr_RD_SYN,
  output logic [ADDR_WIDTH:0]   ADDR_W,
  output logic [ADDR_WIDTH:0]   wptr_W,
  output logic                  W_INC,
  output logic                  FULL_FLAG,
  output logic                  ALMOST_FULL,
  output logic [ADDR_WIDTH:0]   W_COUNT,
  output logic                  OVERFLOW
);

  localparam logic [ADDR_WIDTH:0] AF_THR = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0] addr_rd;
  logic [ADDR_WIDTH:0] addr_q;
  logic [ADDR_WIDTH:0] wptr_q;
  logic [ADDR_WIDTH:0] addr_next;
  logic [ADDR_WIDTH:0] wptr_next;
  logic [ADDR_WIDTH:0] count_raw;
  logic                full_raw;
  logic                overflow_q;

  // Gray to binary: each bit is the XOR of all Gray bits at or above it.
  always_comb begin
    addr_rd = '0;
    addr_rd[ADDR_WIDTH] = rptr_RD_SYN[ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
      addr_rd[i] = addr_rd[i+1] ^ rptr_RD_SYN[i];
    end
  end

  assign full_raw  = (addr_q[ADDR_WIDTH] != addr_rd[ADDR_WIDTH]) &&
                     (addr_q[ADDR_WIDTH-1:0] == addr_rd[ADDR_WIDTH-1:0]);
  assign count_raw = addr_q - addr_rd;

  // Status outputs are held low for the whole time reset is asserted.
  assign FULL_FLAG   = W_RST & full_raw;
  assign W_INC       = W_RST & W_EN & ~full_raw;
  assign W_COUNT     = W_RST ? count_raw : '0;
  assign ALMOST_FULL = W_RST & (count_raw >= AF_THR);

  assign addr_next = addr_q + ONE;
  assign wptr_next = addr_next ^ (addr_next >> 1);

  always_ff @(posedge CLK_WRITE or negedge W_RST) begin
    if (!W_RST) begin
      addr_q     <= '0;
      wptr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (W_INC) begin
        addr_q <= addr_next;
        wptr_q <= wptr_next;
      end
      if (W_EN && full_raw) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign ADDR_W   = addr_q;
  assign wptr_W   = wptr_q;
  assign OVERFLOW = overflow_q;

endmodule
